// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and the
// baud-rate code to 16x-tick divisor table.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } tx_state_e;

    localparam int unsigned TICKS_PER_BIT = 16;
    localparam int unsigned DATA_BITS     = 8;

    // Clock cycles per 16x tick for a 50 MHz system clock.
    function automatic logic [15:0] baud_divisor(input logic [2:0] sel);
        logic [15:0] div;
        unique case (sel)
            3'b000:  div = 16'd10417;  // 300
            3'b001:  div = 16'd2604;   // 1200
            3'b010:  div = 16'd651;    // 4800
            3'b011:  div = 16'd326;    // 9600
            3'b100:  div = 16'd163;    // 19200
            3'b101:  div = 16'd81;     // 38400
            3'b110:  div = 16'd54;     // 57600
            default: div = 16'd27;     // 115200
        endcase
        return div;
    endfunction

endpackage

// File: rtl/baud_controller.sv
// Shared 16x oversampling baud tick generator; emits a one-clock pulse every
// baud_divisor(baud_select) clocks.
module baud_controller
    import uart_pkg::*;
(
    input  logic       reset,
    input  logic       clock,
    input  logic [2:0] baud_select,
    output logic       sample_enable
);

    logic [15:0] cnt_q;
    logic        en_q;
    logic [15:0] limit;

    assign limit = baud_divisor(baud_select) - 16'd1;

    // >= rather than == so a runtime baud change never strands the counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else if (cnt_q >= limit) begin
            cnt_q <= '0;
            en_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + 16'd1;
            en_q  <= 1'b0;
        end
    end

    assign sample_enable = en_q;

endmodule

// File: rtl/uart_transmitter.sv
// Double-buffered UART transmitter: start, 8 data bits LSB first, optional even
// parity (UART_TX_PARITY_EN), stop. Bit timing from the shared 16x baud tick.
module uart_transmitter
    import uart_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic [7:0] Tx_DATA,
    input  logic       Tx_WR,
    output logic       Tx_READY,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_DONE,
    output logic       Tx_OVERRUN
);

    logic Tx_sample_ENABLE;

    baud_controller u_baud (
        .reset        (reset),
        .clock        (clock),
        .baud_select  (baud_select),
        .sample_enable(Tx_sample_ENABLE)
    );

    tx_state_e   state_q, state_d;
    logic [3:0]  tick_q, tick_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;
    logic        txd_q, txd_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;
    logic        bit_end;
    logic        load;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            txd_q        <= 1'b1;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            txd_q        <= txd_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        txd_d        = txd_q;
        done_d       = 1'b0;
        overrun_d    = overrun_q;
        load         = 1'b0;
        bit_end      = (tick_q == 4'(TICKS_PER_BIT - 1));
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif

        if (Tx_WR) begin
            if (!hold_valid_q) begin
                hold_d       = Tx_DATA;
                hold_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (Tx_sample_ENABLE) begin
            if (state_q != IDLE) begin
                tick_d = tick_q + 4'd1;
            end
            case (state_q)
                IDLE: begin
                    load = hold_valid_q && Tx_EN;
                end
                START: begin
                    if (bit_end) begin
                        state_d = DATA;
                        txd_d   = shift_q[0];
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
                            txd_d   = parity_q;
`else
                            state_d = STOP;
                            txd_d   = 1'b1;
`endif
                        end else begin
                            shift_d = shift_q >> 1;
                            txd_d   = shift_q[1];
                            idx_d   = idx_q + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        done_d = 1'b1;
                        if (hold_valid_q && Tx_EN) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            txd_d   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                    tick_d  = '0;
                end
            endcase

            // Loading implies hold_valid_q=1, so no write can collide with the clear.
            if (load) begin
                shift_d      = hold_q;
                hold_valid_d = 1'b0;
                state_d      = START;
                txd_d        = 1'b0;
                tick_d       = '0;
`ifdef UART_TX_PARITY_EN
                parity_d     = ^hold_q;
`endif
            end
        end
    end

    assign Tx_READY   = !hold_valid_q;
    assign TxD        = txd_q;
    assign Tx_BUSY    = (state_q != IDLE);
    assign Tx_DONE    = done_q;
    assign Tx_OVERRUN = overrun_q;

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit stage that feeds the `RxD` input of the UART receiver: it accepts bytes over a ready/write handshake, then shifts each one out as a framed serial stream on `TxD`. Each frame is start bit, 8 data bits LSB first, even parity bit, stop bit. A one-byte holding register gives double buffering, so frames go out back-to-back with no idle gap. Bit timing comes from the shared 16x oversampling baud tick, so the frame format and bit period are identical to what the receiver samples.

## Interface
- No parameters; frame format fixed, baud rate runtime-selected.
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `baud_select`  in  3  baud rate code, same encoding as the receiver.
- `Tx_EN`  in  1  transmit enable; gates the start of new frames only.
- `Tx_DATA`  in  8  byte to send; sampled when `Tx_WR`=1 and `Tx_READY`=1.
- `Tx_WR`  in  1  write strobe, one clock per byte.
- `Tx_READY`  out  1  holding register empty; combinational, equals !hold_valid.
- `TxD`  out  1  serial line, registered; idle high.
- `Tx_BUSY`  out  1  shifter active, i.e. state != IDLE.
- `Tx_DONE`  out  1  one-clock pulse at the end of each stop bit.
- `Tx_OVERRUN`  out  1  sticky; set by a write while `Tx_READY`=0.

## Operation
- Tick: `Tx_sample_ENABLE` is a one-clock pulse at 16x baud. All FSM and counter state advances only on clock edges where the tick is 1.
- Bit counter `tick_cnt[3:0]` counts 0..15 per bit and wraps to 0. A bit ends on a tick with `tick_cnt`==15. One bit lasts 16 ticks.
- Holding register:
  - `Tx_WR` with `Tx_READY`=1 latches `Tx_DATA` and sets hold_valid.
  - `Tx_WR` with `Tx_READY`=0 is ignored: data is dropped and `Tx_OVERRUN` is set.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `TxD`=1, `tick_cnt` held at 0. On a tick with hold_valid=1 and `Tx_EN`=1, the following happen on the same edge:
    - shift register loads from the holding register;
    - parity register is set to the XOR of the byte;
    - hold_valid clears;
    - state goes to START and `TxD` goes to 0.
  - START → DATA at bit end. `TxD` = shift[0]; bit index = 0.
  - DATA: at each bit end, shift right and increment the index. After bit index 7 ends, go to PARITY with `TxD` = parity.
  - PARITY → STOP at bit end, `TxD`=1.
  - STOP at bit end:
    - `Tx_DONE` pulses.
    - If hold_valid=1 and `Tx_EN`=1: load the next byte and go directly to START (`TxD`=0).
    - Otherwise go to IDLE.
- `Tx_EN` dropped mid-frame: the current frame completes; no new frame starts until `Tx_EN` returns.
- Write on the same edge the shifter loads: impossible by construction, because loading requires hold_valid=1, which makes `Tx_READY`=0.
- Reset mid-frame: the frame is aborted; all outputs return to reset values immediately.

## Timing
- Reset values: `TxD`=1, `Tx_BUSY`=0, `Tx_DONE`=0, `Tx_OVERRUN`=0, `Tx_READY`=1, state IDLE, hold_valid=0, `tick_cnt`=0.
- Write-to-start latency: start bit begins on the first tick edge after the write edge, i.e. ≤ 16x-tick period + 1 clock.
- Frame length is exactly 176 ticks: 11 bits × 16.
- `TxD` changes only on tick edges with `tick_cnt`==15, or on the IDLE→START load edge.
- `Tx_READY` rises on the load edge, giving a full frame time to supply the next byte without a gap.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: PARITY state present, 11-bit frame, even parity matching the receiver.
  - Undefined: PARITY state skipped (DATA → STOP), 10-bit frame of 160 ticks.
- Production builds define it.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants (IDLE=3'b000, START=3'b001, DATA=3'b010, PARITY=3'b011, STOP=3'b100);
  - `TICKS_PER_BIT`=16;
  - `DATA_BITS`=8.
- One sub-module: instantiate the existing `baud_controller(reset, clock, baud_select, Tx_sample_ENABLE)`. Do not re-implement the divider.

## Test plan
- Reset, `Tx_EN`=1, baud_select=3'b111, write 8'hA5 → `TxD` sequence 0,1,0,1,0,0,1,0,1,0,1 (start, LSB first, parity 0, stop), 16 ticks per bit; one `Tx_DONE` pulse; `Tx_BUSY` low afterwards.
- Write 8'h01, then 8'h80 while the first frame is in DATA → `Tx_READY` low until the second load; the second frame's start bit directly follows the first stop bit (no idle tick); parity bits are 1 and 1.
- Third write while hold full and shifter busy → `Tx_OVERRUN`=1 and stays 1; the dropped byte never appears on `TxD`.
- `Tx_EN`=0, write 8'h3C → `TxD` stays 1 and `Tx_READY`=0; raise `Tx_EN` → frame starts on the next tick.
- Assert `reset` mid-DATA of 8'hFF → `TxD`=1, `Tx_BUSY`=0, `Tx_READY`=1 immediately; no `Tx_DONE`.
- Loopback into the UART receiver, bytes 8'h00, 8'h55, 8'hFF → `Rx_DATA` matches each, `Rx_VALID`=1, `Rx_PERROR`=`Rx_FERROR`=0. With `UART_TX_PARITY_EN` undefined → 160-tick frames.
